// File: rtl/gol_pkg.sv
// Shared Game-of-Life definitions: default field size, address-width helper
// and the loader state encoding.
package gol_pkg;

  localparam int DEFAULT_FIELD_W = 5;
  localparam int DEFAULT_FIELD_H = 3;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } loader_state_t;

  // Width needed to address n cells; never narrower than one bit.
  function automatic int adr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/field_cfg_loader_if.sv
// Coordinate bus between the field configuration loader and the field storage.
// o_done exists only when FIELD_CFG_LOADER_DONE_EN is defined.
interface field_cfg_loader_if
  import gol_pkg::*;
#(
  parameter int X_ADR_SIZE = adr_width(DEFAULT_FIELD_W),
  parameter int Y_ADR_SIZE = adr_width(DEFAULT_FIELD_H)
) ();

  logic                  i_go;
  logic                  o_is_loading;
  logic [X_ADR_SIZE-1:0] o_cur_x;
  logic [Y_ADR_SIZE-1:0] o_cur_y;
`ifdef FIELD_CFG_LOADER_DONE_EN
  logic                  o_done;

  modport master (
    input  i_go,
    output o_is_loading,
    output o_cur_x,
    output o_cur_y,
    output o_done
  );

  modport slave (
    output i_go,
    input  o_is_loading,
    input  o_cur_x,
    input  o_cur_y,
    input  o_done
  );
`else
  modport master (
    input  i_go,
    output o_is_loading,
    output o_cur_x,
    output o_cur_y
  );

  modport slave (
    output i_go,
    input  o_is_loading,
    input  o_cur_x,
    input  o_cur_y
  );
`endif

endinterface

// File: rtl/wrap_counter.sv
// Modulo-MODULUS counter with synchronous clear and enable; o_at_max flags
// the last value so a neighbouring counter can chain off it.
module wrap_counter
  import gol_pkg::*;
#(
  parameter  int MODULUS = 2,
  localparam int W       = adr_width(MODULUS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_at_max
);

  // Compare at full 32-bit width so no out-of-range value can ever match.
  localparam logic [31:0] LAST = 32'(MODULUS - 1);

  logic [W-1:0] r_count;
  logic         w_at_max;

  assign w_at_max = (32'(r_count) == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_at_max ? '0 : r_count + 1'b1;
    end
  end

  assign o_count  = r_count;
  assign o_at_max = w_at_max;

endmodule

// File: rtl/field_cfg_loader.sv
// Walks every field cell in row-major order after one i_go pulse.
// Optional o_done pulse on scan completion: define FIELD_CFG_LOADER_DONE_EN.
module field_cfg_loader
  import gol_pkg::*;
#(
  parameter  int FIELD_W    = DEFAULT_FIELD_W,
  parameter  int FIELD_H    = DEFAULT_FIELD_H,
  localparam int X_ADR_SIZE = adr_width(FIELD_W),
  localparam int Y_ADR_SIZE = adr_width(FIELD_H)
) (
  input  logic               clk,
  input  logic               rst,
  field_cfg_loader_if.master bus
);

  loader_state_t         r_state;
  loader_state_t         w_state_nxt;
  logic                  w_in_load;
  logic                  w_last_cell;
  logic [X_ADR_SIZE-1:0] w_x;
  logic [Y_ADR_SIZE-1:0] w_y;
  logic                  w_x_at_max;
  logic                  w_y_at_max;

  assign w_in_load   = (r_state == LOAD);
  assign w_last_cell = w_in_load & w_x_at_max & w_y_at_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // i_go only matters in IDLE; a running scan always completes undisturbed.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.i_go) w_state_nxt = LOAD;
      LOAD:    if (w_last_cell) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Both counters wrap to zero on the final cell, so IDLE always shows (0,0).
  wrap_counter #(.MODULUS(FIELD_W)) u_x_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (!w_in_load),
    .i_en     (w_in_load),
    .o_count  (w_x),
    .o_at_max (w_x_at_max)
  );

  wrap_counter #(.MODULUS(FIELD_H)) u_y_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (!w_in_load),
    .i_en     (w_in_load & w_x_at_max),
    .o_count  (w_y),
    .o_at_max (w_y_at_max)
  );

  assign bus.o_is_loading = w_in_load;
  assign bus.o_cur_x      = w_x;
  assign bus.o_cur_y      = w_y;

`ifdef FIELD_CFG_LOADER_DONE_EN
  logic r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_last_cell;
    end
  end

  assign bus.o_done = r_done;
`endif

endmodule

// File: tb/tb_field_cfg_loader.sv
// Self-checking bench for field_cfg_loader (5x3 field): fixed vector table,
// hand-written corner sequences and random i_go against a cell-index model.
module tb_field_cfg_loader;
  import gol_pkg::*;

  localparam int FW = 5;
  localparam int FH = 3;
  localparam int N  = FW * FH;

  logic clk = 1'b0;
  logic rst = 1'b0;

  field_cfg_loader_if #(
    .X_ADR_SIZE (adr_width(FW)),
    .Y_ADR_SIZE (adr_width(FH))
  ) bus ();

  field_cfg_loader #(
    .FIELD_W (FW),
    .FIELD_H (FH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #20;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  int checks   = 0;
  int failures = 0;

  // Reference model: a scan is just a running cell index 0..N-1.
  bit mBusy = 1'b0;
  int mIdx  = 0;
  bit mDone = 1'b0;

  typedef struct {
    bit go;
    bit loading;
    int x;
    int y;
  } vec_t;

  vec_t vecs[17];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mBusy = 1'b0;
    mIdx  = 0;
    mDone = 1'b0;
  endtask

  task automatic modelEdge(input bit go);
    mDone = 1'b0;
    if (mBusy) begin
      if (mIdx == N - 1) begin
        mBusy = 1'b0;
        mIdx  = 0;
        mDone = 1'b1;
      end else begin
        mIdx++;
      end
    end else if (go) begin
      mBusy = 1'b1;
      mIdx  = 0;
    end
  endtask

  task automatic checkModel(input string tag);
    int ex;
    int ey;
    ex = mBusy ? (mIdx % FW) : 0;
    ey = mBusy ? (mIdx / FW) : 0;
    checkOutput({tag, " loading"}, 32'(bus.o_is_loading), 32'(mBusy));
    checkOutput({tag, " x"}, 32'(bus.o_cur_x), 32'(ex));
    checkOutput({tag, " y"}, 32'(bus.o_cur_y), 32'(ey));
`ifdef FIELD_CFG_LOADER_DONE_EN
    checkOutput({tag, " done"}, 32'(bus.o_done), 32'(mDone));
`endif
  endtask

  task automatic applyStimulus(input bit go, input string tag);
    bus.i_go = go;
    @(posedge clk);
    modelEdge(go);
    #1;
    checkModel(tag);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 0, 0};
    vecs[1]  = '{1'b0, 1'b1, 1, 0};
    vecs[2]  = '{1'b0, 1'b1, 2, 0};
    vecs[3]  = '{1'b0, 1'b1, 3, 0};
    vecs[4]  = '{1'b0, 1'b1, 4, 0};
    vecs[5]  = '{1'b0, 1'b1, 0, 1};
    vecs[6]  = '{1'b0, 1'b1, 1, 1};
    vecs[7]  = '{1'b1, 1'b1, 2, 1};
    vecs[8]  = '{1'b0, 1'b1, 3, 1};
    vecs[9]  = '{1'b0, 1'b1, 4, 1};
    vecs[10] = '{1'b0, 1'b1, 0, 2};
    vecs[11] = '{1'b0, 1'b1, 1, 2};
    vecs[12] = '{1'b0, 1'b1, 2, 2};
    vecs[13] = '{1'b0, 1'b1, 3, 2};
    vecs[14] = '{1'b0, 1'b1, 4, 2};
    vecs[15] = '{1'b0, 1'b0, 0, 0};
    vecs[16] = '{1'b0, 1'b0, 0, 0};

    // Asynchronous reset with no clock edge in the window.
    bus.i_go = 1'b0;
    #2 rst = 1'b1;
    #3;
    modelReset();
    checkModel("reset_async");
    #2 rst = 1'b0;
    #1;
    checkModel("reset_release");

    $display("[TB] full scan from vector table");
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].go, "table");
      checkOutput($sformatf("table[%0d] loading", i), 32'(bus.o_is_loading), 32'(vecs[i].loading));
      checkOutput($sformatf("table[%0d] x", i), 32'(bus.o_cur_x), 32'(vecs[i].x));
      checkOutput($sformatf("table[%0d] y", i), 32'(bus.o_cur_y), 32'(vecs[i].y));
    end

    $display("[TB] back-to-back scans with random gaps");
    repeat (3) begin
      int gap;
      gap = $urandom_range(1, 10);
      repeat (gap) applyStimulus(1'b0, "b2b_idle");
      applyStimulus(1'b1, "b2b_start");
      for (int k = 1; k < N; k++) applyStimulus(1'($urandom_range(0, 1)), "b2b_scan");
      applyStimulus(1'b0, "b2b_end");
    end

    $display("[TB] i_go held high across scans");
    repeat (2) applyStimulus(1'b0, "held_pre");
    for (int j = 0; j < 40; j++) begin
      applyStimulus(1'b1, "held");
      checkOutput($sformatf("held_pattern[%0d]", j), 32'(bus.o_is_loading),
                  32'((j % (N + 1)) != N));
    end
    for (int k = 0; k < N + 2 && mBusy; k++) applyStimulus(1'b0, "held_drain");
    checkOutput("held_drained", 32'(bus.o_is_loading), 32'd0);

    $display("[TB] reset in the middle of a scan");
    applyStimulus(1'b1, "mid_start");
    for (int k = 1; k <= 7; k++) applyStimulus(1'b0, "mid_scan");
    checkOutput("mid_at_x", 32'(bus.o_cur_x), 32'd2);
    checkOutput("mid_at_y", 32'(bus.o_cur_y), 32'd1);
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkModel("mid_reset");
    #3 rst = 1'b0;
    repeat (3) applyStimulus(1'b0, "mid_after");
    applyStimulus(1'b1, "mid_restart");
    checkOutput("restart_loading", 32'(bus.o_is_loading), 32'd1);
    checkOutput("restart_x", 32'(bus.o_cur_x), 32'd0);
    checkOutput("restart_y", 32'(bus.o_cur_y), 32'd0);
    for (int k = 1; k <= N; k++) applyStimulus(1'b0, "mid_rescan");

    $display("[TB] random i_go traffic");
    for (int k = 0; k < 200; k++) applyStimulus(($urandom_range(0, 7) == 0), "random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
